// File: rtl/fan_run_sequencer.sv
// Run-control FSM for the fan: arbitrates button pulses, reservation expiry and
// obstacle stop into one power level, ramped duty, rotation enable and timer commands.
module fan_run_sequencer #(
    parameter int          RAMP_DIV   = 100000,
    parameter int          RESUME_CYC = 50000000,
    parameter logic [7:0]  DUTY_L1    = 8'd85,
    parameter logic [7:0]  DUTY_L2    = 8'd170,
    parameter logic [7:0]  DUTY_L3    = 8'd255
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] btn_pe,
    input  logic       timer_end,
    input  logic       obstacle,
    output logic [1:0] power_level,
    output logic [7:0] duty,
    output logic [2:0] led_power,
    output logic       rotate_en,
    output logic [1:0] timer_sel,
    output logic       timer_load,
    output logic       motor_idle
);

    localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int RW = (RESUME_CYC > 1) ? $clog2(RESUME_CYC + 1) : 1;
    localparam logic [PW-1:0] PRESC_MAX  = PW'(RAMP_DIV - 1);
    localparam logic [RW-1:0] RESUME_MAX = RW'(RESUME_CYC - 1);

    typedef enum logic [1:0] {IDLE, RAMP, RUN, HOLD} state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [RW-1:0] resume_cnt;
    logic [7:0]    target;
    logic [1:0]    next_level;
    logic          pwr, tmr, rot;
    logic          unused_btn;

    assign pwr        = btn_pe[0];
    assign tmr        = btn_pe[2];
    assign rot        = btn_pe[3];
    assign unused_btn = btn_pe[1];
    assign next_level = power_level + 2'd1;

    always_comb begin
        target = 8'd0;
        case (power_level)
            2'd1:    target = DUTY_L1;
            2'd2:    target = DUTY_L2;
            2'd3:    target = DUTY_L3;
            default: target = 8'd0;
        endcase
    end

    function automatic logic [2:0] led_of(input logic [1:0] lvl);
        case (lvl)
            2'd1:    return 3'b001;
            2'd2:    return 3'b010;
            2'd3:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            power_level <= 2'd0;
            duty        <= 8'd0;
            led_power   <= 3'b000;
            rotate_en   <= 1'b0;
            timer_sel   <= 2'd0;
            timer_load  <= 1'b0;
            motor_idle  <= 1'b1;
            presc       <= '0;
            resume_cnt  <= '0;
        end else begin
            timer_load <= 1'b0;

            // Free-running progression; the event chain below overrides it.
            case (state)
                RAMP: begin
                    if (duty == target && target != 8'd0) begin
                        state <= RUN;
                    end else if (duty == 8'd0 && target == 8'd0) begin
                        state      <= IDLE;
                        motor_idle <= 1'b1;
                        rotate_en  <= 1'b0;
                    end else if (presc == PRESC_MAX) begin
                        presc <= '0;
                        duty  <= (duty < target) ? duty + 8'd1 : duty - 8'd1;
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                HOLD: begin
                    if (resume_cnt == RESUME_MAX) begin
                        state      <= RAMP;
                        presc      <= '0;
                        resume_cnt <= '0;
                    end else begin
                        resume_cnt <= resume_cnt + 1'b1;
                    end
                end
                default: ;
            endcase

            if (timer_end && state != IDLE) begin
                power_level <= 2'd0;
                led_power   <= 3'b000;
                timer_sel   <= 2'd0;
                rotate_en   <= 1'b0;
                presc       <= '0;
                resume_cnt  <= '0;
                if (state == HOLD) begin
                    state      <= IDLE;
                    motor_idle <= 1'b1;
                end else begin
                    state <= RAMP;
                end
            end else if (obstacle && state != IDLE) begin
                state      <= HOLD;
                duty       <= 8'd0;
                rotate_en  <= 1'b0;
                resume_cnt <= '0;
            end else if (pwr) begin
                power_level <= next_level;
                led_power   <= led_of(next_level);
                if (state == HOLD) begin
                    if (next_level == 2'd0) begin
                        state      <= IDLE;
                        motor_idle <= 1'b1;
                    end else begin
                        state <= HOLD;
                    end
                end else begin
                    state      <= RAMP;
                    presc      <= '0;
                    motor_idle <= 1'b0;
                end
            end else if (tmr && power_level != 2'd0) begin
                timer_sel  <= timer_sel + 2'd1;
                timer_load <= 1'b1;
            end else if (rot && (state == RAMP || state == RUN) && target != 8'd0) begin
                rotate_en <= !rotate_en;
            end
        end
    end

endmodule

// File: tb/tb_fan_run_sequencer.sv
// Directed scoreboard bench for fan_run_sequencer with shortened ramp/resume timing.
module tb_fan_run_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] btn_pe = 4'd0;
    logic       timer_end = 1'b0;
    logic       obstacle = 1'b0;
    logic [1:0] power_level;
    logic [7:0] duty;
    logic [2:0] led_power;
    logic       rotate_en;
    logic [1:0] timer_sel;
    logic       timer_load;
    logic       motor_idle;

    always #5 clk = ~clk;

    fan_run_sequencer #(
        .RAMP_DIV(4), .RESUME_CYC(8),
        .DUTY_L1(8'd8), .DUTY_L2(8'd16), .DUTY_L3(8'd24)
    ) dut (
        .clk(clk), .reset_n(reset_n), .btn_pe(btn_pe), .timer_end(timer_end),
        .obstacle(obstacle), .power_level(power_level), .duty(duty),
        .led_power(led_power), .rotate_en(rotate_en), .timer_sel(timer_sel),
        .timer_load(timer_load), .motor_idle(motor_idle)
    );

    typedef struct packed {
        logic [1:0] pl;
        logic [7:0] duty;
        logic [2:0] led;
        logic       rot;
        logic [1:0] tsel;
        logic       tload;
        logic       idle;
    } obs_t;

    obs_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   pl_b = 0, rot_b = 0, tsel_b = 0;

    function automatic obs_t mk(int pl, int d, int r, int ts, int tl, int idl);
        obs_t e;
        e.pl    = 2'(pl);
        e.duty  = 8'(d);
        e.led   = (pl == 1) ? 3'b001 : (pl == 2) ? 3'b010 : (pl == 3) ? 3'b100 : 3'b000;
        e.rot   = 1'(r);
        e.tsel  = 2'(ts);
        e.tload = 1'(tl);
        e.idle  = 1'(idl);
        return e;
    endfunction

    task automatic apply(input string tag, input logic [3:0] btn, input logic te,
                         input logic ob, input obs_t e);
        obs_t o, x;
        btn_pe    = btn;
        timer_end = te;
        obstacle  = ob;
        q.push_back(e);
        @(posedge clk);
        #1;
        btn_pe    = 4'd0;
        timer_end = 1'b0;
        o = {power_level, duty, led_power, rotate_en, timer_sel, timer_load, motor_idle};
        x = q.pop_front();
        vectors++;
        assert (o === x) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, o, x);
        end
    endtask

    // Duty moves one step per 4 cycles; a ramp to zero lands in IDLE one cycle after duty hits 0.
    task automatic ramp(input string tag, input int from, input int to, input int ncyc);
        int d, idl;
        for (int k = 1; k <= ncyc; k++) begin
            if (from < to) d = (from + k / 4 > to) ? to : from + k / 4;
            else           d = (from - k / 4 < to) ? to : from - k / 4;
            idl = (to == 0 && k > 4 * from) ? 1 : 0;
            if (idl == 1) rot_b = 0;
            apply(tag, 4'd0, 1'b0, 1'b0, mk(pl_b, d, rot_b, tsel_b, 0, idl));
        end
    endtask

    initial begin
        #1;
        apply("reset", 4'd0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 1));
        apply("reset_hold", 4'd0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 1));
        reset_n = 1'b1;

        apply("rot_idle", 4'b1000, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 1));
        apply("tmr_lvl0", 4'b0100, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 1));
        apply("btn1_ignored", 4'b0010, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 1));
        apply("tend_idle", 4'd0, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 1));

        // Level 1 -> 2 -> 3, then power off from level 3 with rotation on.
        apply("pwr_on", 4'b0001, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 0)); pl_b = 1;
        ramp("ramp_l1", 0, 8, 34);
        apply("pwr_l2", 4'b0001, 1'b0, 1'b0, mk(2, 8, 0, 0, 0, 0)); pl_b = 2;
        ramp("ramp_l2", 8, 16, 34);
        apply("pwr_l3", 4'b0001, 1'b0, 1'b0, mk(3, 16, 0, 0, 0, 0)); pl_b = 3;
        ramp("ramp_l3", 16, 24, 34);
        apply("rot_run", 4'b1000, 1'b0, 1'b0, mk(3, 24, 1, 0, 0, 0)); rot_b = 1;
        apply("pwr_off", 4'b0001, 1'b0, 1'b0, mk(0, 24, 1, 0, 0, 0)); pl_b = 0;
        ramp("ramp_off", 24, 0, 98);

        // Back up to level 2, then obstacle hold and resume.
        apply("pwr_on2", 4'b0001, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 0)); pl_b = 1;
        ramp("ramp_l1b", 0, 8, 34);
        apply("pwr_l2b", 4'b0001, 1'b0, 1'b0, mk(2, 8, 0, 0, 0, 0)); pl_b = 2;
        ramp("ramp_l2b", 8, 16, 34);
        apply("rot_run2", 4'b1000, 1'b0, 1'b0, mk(2, 16, 1, 0, 0, 0)); rot_b = 1;
        apply("obs_hit", 4'd0, 1'b0, 1'b1, mk(2, 0, 0, 0, 0, 0)); rot_b = 0;
        for (int i = 0; i < 4; i++) apply("obs_hold", 4'd0, 1'b0, 1'b1, mk(2, 0, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++) apply("clr_a", 4'd0, 1'b0, 1'b0, mk(2, 0, 0, 0, 0, 0));
        apply("obs_again", 4'd0, 1'b0, 1'b1, mk(2, 0, 0, 0, 0, 0));
        for (int i = 0; i < 7; i++) apply("clr_b", 4'd0, 1'b0, 1'b0, mk(2, 0, 0, 0, 0, 0));
        apply("resume", 4'd0, 1'b0, 1'b0, mk(2, 0, 0, 0, 0, 0));
        ramp("ramp_resume", 0, 16, 66);

        // Timer presets cycle with one load pulse each.
        apply("tmr1", 4'b0100, 1'b0, 1'b0, mk(2, 16, 0, 1, 1, 0));
        apply("tload_drop1", 4'd0, 1'b0, 1'b0, mk(2, 16, 0, 1, 0, 0));
        apply("tmr2", 4'b0100, 1'b0, 1'b0, mk(2, 16, 0, 2, 1, 0));
        apply("tmr3", 4'b0100, 1'b0, 1'b0, mk(2, 16, 0, 3, 1, 0));
        apply("tload_drop3", 4'd0, 1'b0, 1'b0, mk(2, 16, 0, 3, 0, 0)); tsel_b = 3;

        // Expiry beats a simultaneous power pulse: soft stop, no timer load.
        apply("tend_pwr", 4'b0001, 1'b1, 1'b0, mk(0, 16, 0, 0, 0, 0));
        pl_b = 0; tsel_b = 0;
        ramp("soft_stop", 16, 0, 66);

        // Reset in the middle of a ramp.
        apply("pwr_on3", 4'b0001, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 0)); pl_b = 1;
        ramp("ramp_to5", 0, 8, 20);
        reset_n = 1'b0;
        apply("reset_mid", 4'd0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 1));
        reset_n = 1'b1; pl_b = 0;
        apply("post_reset", 4'd0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
